// File: rtl/stopwatch_pkg.sv
// Shared types and BCD digit helpers for the stopwatch core and its lap FIFO.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        STOP    = 2'd0,
        RUN     = 2'd1,
        ADJUST  = 2'd2,
        EXPIRED = 2'd3
    } sw_state_t;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t min_tens;
        bcd_t min_ones;
        bcd_t sec_tens;
        bcd_t sec_ones;
    } sw_time_t;

    localparam sw_time_t TIME_ZERO = '0;

    // Out-of-range inputs fold back to 0 so a digit can never leave its legal range.
    function automatic bcd_t bcd_inc(input bcd_t d, input bcd_t top);
        return (d >= top) ? 4'd0 : d + 4'd1;
    endfunction

    function automatic bcd_t bcd_dec(input bcd_t d, input bcd_t top);
        return (d == 4'd0) ? top : d - 4'd1;
    endfunction

endpackage

// File: rtl/stopwatch_core_if.sv
// Control, display and lap-readout signals of the stopwatch core.
interface stopwatch_core_if #(
    parameter int LAP_DEPTH = 4
);
    import stopwatch_pkg::*;

    localparam int CW = $clog2(LAP_DEPTH) + 1;

    logic          start_stop;
    logic          lap;
    logic          adj;
    logic          sel;
    logic          dir;
    logic          lap_rd;
    bcd_t          min_tens;
    bcd_t          min_ones;
    bcd_t          sec_tens;
    bcd_t          sec_ones;
    logic          running;
    logic          expired;
    logic          lap_valid;
    logic [15:0]   lap_data;
    logic          lap_full;
    logic [CW-1:0] lap_count;

    modport master (
        output start_stop, lap, adj, sel, dir, lap_rd,
        input  min_tens, min_ones, sec_tens, sec_ones,
        input  running, expired, lap_valid, lap_data, lap_full, lap_count
    );

    modport slave (
        input  start_stop, lap, adj, sel, dir, lap_rd,
        output min_tens, min_ones, sec_tens, sec_ones,
        output running, expired, lap_valid, lap_data, lap_full, lap_count
    );

endinterface

// File: rtl/lap_fifo.sv
// Synchronous lap-capture FIFO; the head is held on o_data after the FIFO drains.
module lap_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic [WIDTH-1:0]       i_data,
    output logic                   o_valid,
    output logic                   o_full,
    output logic [$clog2(DEPTH):0] o_count,
    output logic [WIDTH-1:0]       o_data
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [WIDTH-1:0] r_hold;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_valid   = (r_count != '0);
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_count   = r_count;
    assign w_pop_ok  = i_pop && o_valid;
    // A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
    assign w_push_ok = i_push && (!o_full || w_pop_ok);
    assign o_data    = o_valid ? r_mem[r_rd_ptr] : r_hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_hold   <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + {{AW{1'b0}}, w_push_ok} - {{AW{1'b0}}, w_pop_ok};
            if (o_valid) r_hold <= r_mem[r_rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/stopwatch_core.sv
// MM:SS BCD stopwatch with run/pause, field adjust, countdown expiry and lap FIFO.
//   state   | meaning
//   STOP    | time frozen, prescaler held
//   RUN     | time steps up/down on every tick1
//   ADJUST  | selected field steps up on every tick2
//   EXPIRED | countdown reached 00:00, waits for start_stop
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int DIV_1HZ   = 100_000_000,
    parameter int LAP_DEPTH = 4,
    parameter int MIN_MAX   = 99
) (
    input logic             clk,
    input logic             rst,
    stopwatch_core_if.slave bus
);
    localparam int      PW    = $clog2(DIV_1HZ);
    localparam [PW-1:0] TC1   = PW'(DIV_1HZ - 1);
    localparam [PW-1:0] TC2   = PW'(DIV_1HZ / 2 - 1);
    localparam bcd_t    MAX_T = bcd_t'(MIN_MAX / 10);
    localparam bcd_t    MAX_O = bcd_t'(MIN_MAX % 10);

    function automatic sw_time_t sec_step(input sw_time_t t);
        sw_time_t r;
        r = t;
        r.sec_ones = bcd_inc(t.sec_ones, 4'd9);
        if (t.sec_ones == 4'd9) r.sec_tens = bcd_inc(t.sec_tens, 4'd5);
        return r;
    endfunction

    function automatic sw_time_t min_step(input sw_time_t t);
        sw_time_t r;
        r = t;
        if (t.min_tens == MAX_T && t.min_ones == MAX_O) begin
            r.min_tens = 4'd0;
            r.min_ones = 4'd0;
        end else begin
            r.min_ones = bcd_inc(t.min_ones, 4'd9);
            if (t.min_ones == 4'd9) r.min_tens = bcd_inc(t.min_tens, 4'd9);
        end
        return r;
    endfunction

    function automatic sw_time_t count_up(input sw_time_t t);
        sw_time_t r;
        r = sec_step(t);
        if (t.sec_tens == 4'd5 && t.sec_ones == 4'd9) r = min_step(r);
        return r;
    endfunction

    // Saturates at 00:00 so a countdown can never wrap to MIN_MAX:59.
    function automatic sw_time_t count_down(input sw_time_t t);
        sw_time_t r;
        r = t;
        if (t != TIME_ZERO) begin
            r.sec_ones = bcd_dec(t.sec_ones, 4'd9);
            if (t.sec_ones == 4'd0) begin
                r.sec_tens = bcd_dec(t.sec_tens, 4'd5);
                if (t.sec_tens == 4'd0) begin
                    r.min_ones = bcd_dec(t.min_ones, 4'd9);
                    if (t.min_ones == 4'd0) r.min_tens = bcd_dec(t.min_tens, 4'd9);
                end
            end
        end
        return r;
    endfunction

    sw_state_t r_state;
    sw_state_t w_state_nxt;
    sw_time_t  r_time;
    sw_time_t  w_time_nxt;
    sw_time_t  w_time_dn;
    logic [PW-1:0] r_presc;
    logic      w_tick1;
    logic      w_tick2;
    logic      w_dn_zero;
    logic      w_running;
    logic      w_expired;
    logic      w_presc_clr;

    assign w_tick1   = (r_presc == TC1);
    assign w_tick2   = (r_presc == TC1) || (r_presc == TC2);
    assign w_time_dn = count_down(r_time);
    assign w_dn_zero = (w_time_dn == TIME_ZERO);

    always_ff @(posedge clk) begin
        if (rst) r_state <= STOP;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bus.adj) begin
            w_state_nxt = ADJUST;
        end else begin
            case (r_state)
                ADJUST:  w_state_nxt = STOP;
                STOP:    if (bus.start_stop && !(bus.dir && r_time == TIME_ZERO)) w_state_nxt = RUN;
                RUN: begin
                    if (bus.start_stop)                        w_state_nxt = STOP;
                    else if (w_tick1 && bus.dir && w_dn_zero)  w_state_nxt = EXPIRED;
                end
                EXPIRED: if (bus.start_stop) w_state_nxt = STOP;
                default: w_state_nxt = STOP;
            endcase
        end
    end

    always_comb begin
        w_running = 1'b0;
        w_expired = 1'b0;
        case (r_state)
            RUN:     w_running = 1'b1;
            EXPIRED: w_expired = 1'b1;
            default: ;
        endcase
    end

    assign w_presc_clr = (w_state_nxt != r_state) && (w_state_nxt == RUN || w_state_nxt == ADJUST);

    always_ff @(posedge clk) begin
        if (rst || w_presc_clr) begin
            r_presc <= '0;
        end else if (r_state == RUN || r_state == ADJUST) begin
            r_presc <= w_tick1 ? '0 : r_presc + PW'(1);
        end
    end

    always_comb begin
        w_time_nxt = r_time;
        if (r_state == RUN && w_tick1)
            w_time_nxt = bus.dir ? w_time_dn : count_up(r_time);
        else if (r_state == ADJUST && w_tick2)
            w_time_nxt = bus.sel ? sec_step(r_time) : min_step(r_time);
    end

    always_ff @(posedge clk) begin
        if (rst) r_time <= TIME_ZERO;
        else     r_time <= w_time_nxt;
    end

    assign bus.min_tens = r_time.min_tens;
    assign bus.min_ones = r_time.min_ones;
    assign bus.sec_tens = r_time.sec_tens;
    assign bus.sec_ones = r_time.sec_ones;
    assign bus.running  = w_running;
    assign bus.expired  = w_expired;

    // Lap data is the registered time, so a same-cycle tick never leaks into the capture.
    lap_fifo #(
        .DEPTH (LAP_DEPTH),
        .WIDTH (16)
    ) u_lap_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (bus.lap),
        .i_pop   (bus.lap_rd),
        .i_data  (r_time),
        .o_valid (bus.lap_valid),
        .o_full  (bus.lap_full),
        .o_count (bus.lap_count),
        .o_data  (bus.lap_data)
    );

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core with a seconds-count reference model checked every cycle.
module tb_stopwatch_core;
    localparam int DIV   = 10;
    localparam int DEPTH = 4;
    localparam int MMAX  = 99;
    localparam int M_STOP = 0, M_RUN = 1, M_ADJ = 2, M_EXP = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stopwatch_core_if #(.LAP_DEPTH(DEPTH)) bus ();

    stopwatch_core #(
        .DIV_1HZ   (DIV),
        .LAP_DEPTH (DEPTH),
        .MIN_MAX   (MMAX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    // Model: time as total seconds, mode, cycles since entering RUN/ADJUST, lap queue.
    int m_mode = M_STOP;
    int m_t    = 0;
    int m_k    = 0;
    logic [15:0] m_hold = '0;
    logic [15:0] m_q[$];

    function automatic logic [15:0] to_bcd16(input int t);
        int m, s;
        m = t / 60;
        s = t % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        int sz, nt, nm;
        bit t1, t2, pop_ok, push_ok, expire;
        if (rst) begin
            m_mode = M_STOP;
            m_t    = 0;
            m_k    = 0;
            m_hold = '0;
            m_q.delete();
        end else begin
            sz = m_q.size();
            if (sz > 0) m_hold = m_q[0];
            pop_ok  = bus.lap_rd && (sz > 0);
            push_ok = bus.lap && ((sz < DEPTH) || pop_ok);
            if (pop_ok)  void'(m_q.pop_front());
            if (push_ok) m_q.push_back(to_bcd16(m_t));

            t1 = (m_k == DIV - 1);
            t2 = ((m_k % (DIV / 2)) == DIV / 2 - 1);
            nt = m_t;
            expire = 1'b0;
            if (m_mode == M_RUN && t1) begin
                if (!bus.dir) begin
                    nt = (m_t + 1) % ((MMAX + 1) * 60);
                end else begin
                    nt = (m_t > 0) ? m_t - 1 : 0;
                    expire = (nt == 0);
                end
            end else if (m_mode == M_ADJ && t2) begin
                if (bus.sel) nt = (m_t / 60) * 60 + ((m_t % 60) + 1) % 60;
                else         nt = (((m_t / 60) + 1) % (MMAX + 1)) * 60 + m_t % 60;
            end

            nm = m_mode;
            if (bus.adj) nm = M_ADJ;
            else if (m_mode == M_ADJ) nm = M_STOP;
            else if (bus.start_stop) begin
                if (m_mode == M_STOP) nm = (bus.dir && m_t == 0) ? M_STOP : M_RUN;
                else                  nm = M_STOP;
            end else if (expire) nm = M_EXP;

            if (nm != m_mode && (nm == M_RUN || nm == M_ADJ)) m_k = 0;
            else if (m_mode == M_RUN || m_mode == M_ADJ)      m_k = (m_k + 1) % DIV;
            m_t    = nt;
            m_mode = nm;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("time", {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones}, to_bcd16(m_t));
            check("running", bus.running, m_mode == M_RUN);
            check("expired", bus.expired, m_mode == M_EXP);
            check("lap_valid", bus.lap_valid, m_q.size() > 0);
            check("lap_full", bus.lap_full, m_q.size() == DEPTH);
            check("lap_count", bus.lap_count, m_q.size());
            check("lap_data", bus.lap_data, (m_q.size() > 0) ? m_q[0] : m_hold);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_ss();
        bus.start_stop = 1'b1;
        @(negedge clk);
        bus.start_stop = 1'b0;
    endtask

    task automatic pulse_lap();
        bus.lap = 1'b1;
        @(negedge clk);
        bus.lap = 1'b0;
    endtask

    task automatic pulse_rd();
        bus.lap_rd = 1'b1;
        @(negedge clk);
        bus.lap_rd = 1'b0;
    endtask

    task automatic adjust_to(input int m, input int s);
        int n;
        n = 0;
        bus.adj = 1'b1;
        bus.sel = 1'b0;
        while ((m_t / 60) != m && n < 3000) begin @(negedge clk); n++; end
        bus.sel = 1'b1;
        while ((m_t % 60) != s && n < 3000) begin @(negedge clk); n++; end
        n_checks++;
        if (n >= 3000) begin
            n_errors++;
            $display("FAIL adjust_to timeout: reached %0d s, wanted %0d:%0d", m_t, m, s);
        end
        bus.adj = 1'b0;
        @(negedge clk);
    endtask

    function automatic logic [15:0] disp();
        return {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones};
    endfunction

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start_stop = 1'b0;
        bus.lap        = 1'b0;
        bus.adj        = 1'b0;
        bus.sel        = 1'b0;
        bus.dir        = 1'b0;
        bus.lap_rd     = 1'b0;
        rst            = 1'b1;
        step(3);
        rst    = 1'b0;
        chk_en = 1'b1;
        check("reset time", disp(), 16'h0000);
        check("reset running", bus.running, 1'b0);
        check("reset lap_count", bus.lap_count, 3'd0);
        check("reset lap_data", bus.lap_data, 16'h0000);

        // Count up across a minute boundary, then pause.
        adjust_to(0, 58);
        bus.dir = 1'b0;
        pulse_ss();
        step(10);
        check("up 00:59", disp(), 16'h0059);
        step(10);
        check("up 01:00", disp(), 16'h0100);
        pulse_ss();
        step(15);
        check("paused time", disp(), 16'h0100);
        check("paused running", bus.running, 1'b0);

        // Wrap at MIN_MAX:59.
        adjust_to(99, 59);
        pulse_ss();
        step(10);
        check("wrap time", disp(), 16'h0000);
        check("wrap running", bus.running, 1'b1);
        check("wrap expired", bus.expired, 1'b0);
        pulse_ss();

        // Countdown to expiry.
        adjust_to(0, 2);
        bus.dir = 1'b1;
        pulse_ss();
        step(10);
        check("down 00:01", disp(), 16'h0001);
        step(10);
        check("down 00:00", disp(), 16'h0000);
        check("expired set", bus.expired, 1'b1);
        step(20);
        check("expired hold", disp(), 16'h0000);
        pulse_ss();
        check("expired clear", bus.expired, 1'b0);
        pulse_ss();
        check("no start at 00:00 down", bus.running, 1'b0);
        bus.dir = 1'b0;

        // Adjust seconds without carry, start_stop ignored in ADJUST.
        adjust_to(5, 58);
        bus.adj = 1'b1;
        bus.sel = 1'b1;
        step(1);
        pulse_ss();
        step(4);
        check("adj 05:59", disp(), 16'h0559);
        check("adj ignores start", bus.running, 1'b0);
        step(5);
        check("adj 05:00", disp(), 16'h0500);

        // Minutes wrap in ADJUST.
        adjust_to(99, 0);
        bus.adj = 1'b1;
        bus.sel = 1'b0;
        step(6);
        check("adj min wrap", disp(), 16'h0000);
        bus.adj = 1'b0;
        step(1);

        // Five laps into a four-deep FIFO; the fifth is dropped.
        for (int i = 1; i <= 5; i++) begin
            adjust_to(0, i);
            pulse_lap();
        end
        check("lap_count full", bus.lap_count, 3'd4);
        check("lap_full", bus.lap_full, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            check("lap order", bus.lap_data, 16'(i));
            pulse_rd();
        end
        check("lap drained", bus.lap_valid, 1'b0);
        check("lap held", bus.lap_data, 16'h0004);

        // Simultaneous push and pop when full.
        for (int i = 6; i <= 9; i++) begin
            adjust_to(0, i);
            pulse_lap();
        end
        adjust_to(0, 10);
        bus.lap    = 1'b1;
        bus.lap_rd = 1'b1;
        @(negedge clk);
        bus.lap    = 1'b0;
        bus.lap_rd = 1'b0;
        check("push+pop count", bus.lap_count, 3'd4);
        check("push+pop head", bus.lap_data, 16'h0007);
        pulse_rd();
        pulse_rd();
        pulse_rd();
        check("newest last", bus.lap_data, 16'h0010);
        pulse_rd();

        // Reset while running.
        adjust_to(3, 17);
        pulse_ss();
        pulse_lap();
        step(3);
        check("pre-rst count", bus.lap_count, 3'd1);
        check("pre-rst time", disp(), 16'h0317);
        rst = 1'b1;
        @(negedge clk);
        check("rst time", disp(), 16'h0000);
        check("rst running", bus.running, 1'b0);
        check("rst fifo", bus.lap_valid, 1'b0);
        rst = 1'b0;
        step(2);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/stopwatch_core.md
Name: stopwatch_core

Overview:
- Parametrised successor to the existing stopwatch counter.
- Holds an MM:SS BCD time value and counts up or down from a single clock, using internal tick enables instead of derived clocks.
- Supports pause, field adjust, countdown expiry and a lap-capture FIFO.
- Drives the existing seven_segment/display path via four BCD digit outputs; lap results are read out through a pop interface.

Parameters:
- DIV_1HZ, 100_000_000: clk cycles per 1 Hz count tick; must be even and >= 4.
- LAP_DEPTH, 4: lap FIFO entries; power of 2, range 2..16.
- MIN_MAX, 99: highest minutes value, 1..99; count-up wraps MIN_MAX:59 -> 00:00.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start_stop  in  1  one-cycle pulse: toggle run/pause
- lap  in  1  one-cycle pulse: capture current time into the lap FIFO
- adj  in  1  level: adjust mode
- sel  in  1  adjust field: 0 = minutes, 1 = seconds
- dir  in  1  0 = count up, 1 = count down
- lap_rd  in  1  one-cycle pulse: pop the lap FIFO head
- min_tens, min_ones, sec_tens, sec_ones  out  4 each  current BCD time
- running  out  1  high in RUN state
- expired  out  1  high in EXPIRED state
- lap_valid  out  1  FIFO non-empty
- lap_data  out  16  FIFO head as {min_tens, min_ones, sec_tens, sec_ones}
- lap_full  out  1  FIFO holds LAP_DEPTH entries
- lap_count  out  $clog2(LAP_DEPTH)+1  number of FIFO entries

Behaviour:
- Reset (sync): state = STOP, time = 00:00, prescaler = 0, FIFO empty. All outputs 0.
- Tick generation:
  - Prescaler counts 0..DIV_1HZ-1. tick1 fires when the count equals DIV_1HZ-1.
  - tick2 fires when the count equals DIV_1HZ/2-1 or DIV_1HZ-1.
  - Prescaler clears on rst and on every transition into RUN or ADJUST. It holds in STOP and EXPIRED.
- States: STOP, RUN, ADJUST, EXPIRED.
- Transitions, in priority order:
  - rst.
  - adj=1 forces ADJUST from any state.
  - In ADJUST, adj falling -> STOP.
  - start_stop: STOP -> RUN; RUN -> STOP; EXPIRED -> STOP, with time left at 00:00. start_stop is ignored in ADJUST.
  - RUN with dir=1 and time reaching 00:00 on a tick1 -> EXPIRED.
  - start_stop in STOP with dir=1 and time 00:00 -> stays STOP (no-op).
- RUN, on tick1 only:
  - dir=0: seconds increment; 59 -> 00 carries into minutes; MIN_MAX:59 -> 00:00 (wrap, no expiry).
  - dir=1: seconds decrement; 00 borrows from minutes.
- ADJUST, on tick2 only:
  - sel=1: seconds increment mod 60, no carry.
  - sel=0: minutes increment mod (MIN_MAX+1).
  - dir is ignored.
- Digit arithmetic:
  - All digits are BCD and stay within legal ranges at all times.
  - Units roll 9 -> 0 with carry into the tens digit; sec_tens range 0..5.
- dir changes while running take effect at the next tick1.
- Lap capture:
  - A lap pulse in any state writes the time as registered in that cycle, i.e. before any same-cycle tick update.
  - lap when full is dropped; no overwrite.
  - lap_rd when empty is ignored.
  - lap and lap_rd in the same cycle when full: pop and push both occur; count is unchanged.
  - lap and lap_rd in the same cycle when empty: push only.
- lap_data is valid only while lap_valid=1; it is held at the previous head otherwise. A pushed entry is visible one cycle after the push.
- Mid-run rst: time, state and FIFO all clear in the next cycle.

Decomposition:
- stopwatch_pkg holds:
  - state enum sw_state_t {STOP, RUN, ADJUST, EXPIRED}
  - bcd_t (4-bit)
  - packed struct sw_time_t {min_tens, min_ones, sec_tens, sec_ones}
  - bcd_inc/bcd_dec helper functions
- Sub-module lap_fifo:
  - Parameters: DEPTH, WIDTH = 16.
  - Synchronous FIFO with push/pop, valid, full and count.
  - Same clk and rst.

Test Plan:
- DIV_1HZ=10, dir=0, pulse start_stop at time 00:58: reads 00:59 after 10 cycles and 01:00 after 20. A further start_stop freezes the time and sets running=0.
- MIN_MAX=2, preload 02:59 via ADJUST, run up: after one tick1 the time is 00:00, expired=0, running=1.
- dir=1 from 00:02, run: 00:01, then 00:00 with expired=1 on the same cycle. Further ticks leave 00:00. start_stop -> STOP, expired=0.
- adj=1, sel=1 starting from 00:58: tick2 every 5 cycles gives 00:59, then 00:00 with minutes unchanged. Repeat with sel=0 from 99:xx: minutes wrap to 00. start_stop in ADJUST has no effect.
- LAP_DEPTH=4: five lap pulses at distinct times leave lap_count=4 and lap_full=1, and the fifth is dropped. Four lap_rd pulses return the first four times in order, then lap_valid=0.
- lap and lap_rd in the same cycle when full: lap_count stays 4 and the newest entry appears last. rst during RUN at 03:17 clears to 00:00, STOP and an empty FIFO on the next cycle.
